// File: rtl/mu0_memory.sv
`default_nettype none
// ============================================================================
//  Module   : mu0_memory
//  Purpose  : Memory system for an MU0-class processor. Provides 4093 words
//             of 16-bit RAM, a free-running cycle counter, an output port
//             register and an input port in one 12-bit word address space. A
//             byte-serial program loader can fill RAM while holding the
//             processor off the bus.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Address map (word addressed)
//    0x000-0xFFC  RAM
//    0xFFD        cycle counter (read value; any write clears it)
//    0xFFE        out_port register (read back / write)
//    0xFFF        in_port (read only; writes are ignored)
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   system clock
//    rst           in   1   synchronous active-high reset
//    address       in  12   processor word address
//    data_in       in  16   processor write data
//    data_out      out 16   processor read data, combinational, 0 when idle
//    memory_read   in   1   processor read enable
//    memory_write  in   1   processor write enable
//    in_port       in  16   external switch inputs
//    out_port      out 16   registered output port
//    load_start    in   1   begin program load (pulse)
//    load_end      in   1   end program load (pulse)
//    byte_valid    in   1   loader byte offered
//    byte_data     in   8   loader byte (high byte first, then low byte)
//    byte_ready    out  1   loader byte accepted when high with byte_valid
//    cpu_hold      out  1   high while loading; holds the processor in reset
//    load_count    out 12   words written by the current or last load
// ============================================================================
module mu0_memory (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [15:0] in_port,
  output logic [15:0] out_port,
  input  logic        load_start,
  input  logic        load_end,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        cpu_hold,
  output logic [11:0] load_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          RAM_WORDS  = 4093;
  localparam logic [11:0] C_RAM_LAST = 12'hFFC;
  localparam logic [11:0] C_CNT_ADDR = 12'hFFD;
  localparam logic [11:0] C_OUT_ADDR = 12'hFFE;
  localparam logic [11:0] C_IN_ADDR  = 12'hFFF;

  // Loader states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [15:0] mem_q [0:RAM_WORDS-1];

  logic [1:0]  state_q,     state_d;
  logic [11:0] load_addr_q, load_addr_d;
  logic [11:0] load_cnt_q,  load_cnt_d;
  logic [7:0]  hi_byte_q,   hi_byte_d;
  logic [15:0] counter_q,   counter_d;
  logic [15:0] out_port_q,  out_port_d;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic        w_loading;
  logic        w_cpu_we;
  logic        w_cpu_ram_we;
  logic        w_ld_take;
  logic        w_ld_ram_we;
  logic        w_ram_we;
  logic [11:0] w_ram_addr;
  logic [15:0] w_ram_wdata;

  assign w_loading = (state_q != ST_IDLE);

  // Processor writes are locked out for the whole load.
  assign w_cpu_we     = memory_write & ~w_loading;
  assign w_cpu_ram_we = w_cpu_we & (address <= C_RAM_LAST);

  // A byte is consumed in HI/LO only when load_end is not present in the same
  // cycle; load_end wins and the byte is simply dropped.
  assign w_ld_take = w_loading & byte_valid & ~load_end;

  // The low byte completes a word. Words aimed at 0xFFD or beyond would land
  // on the I/O registers, so they are discarded. rst suppresses the write so
  // an aborted load never leaves a half-finished word behind.
  assign w_ld_ram_we = w_ld_take & (state_q == ST_LO) &
                       (load_addr_q < C_CNT_ADDR) & ~rst;

  // Loader and processor writes are mutually exclusive: the loader writes
  // only while cpu_hold is high, which blocks the processor.
  assign w_ram_we    = w_ld_ram_we | w_cpu_ram_we;
  assign w_ram_addr  = w_ld_ram_we ? load_addr_q : address;
  assign w_ram_wdata = w_ld_ram_we ? {hi_byte_q, byte_data} : data_in;

  // --------------------------------------------------------------------------
  // Loader next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    load_cnt_d  = load_cnt_q;
    hi_byte_d   = hi_byte_q;

    case (state_q)
      ST_IDLE: begin
        // load_count keeps its last value here until a new load begins.
        if (load_start) begin
          state_d     = ST_HI;
          load_addr_d = 12'h000;
          load_cnt_d  = 12'h000;
        end
      end

      ST_HI: begin
        if (load_end) begin
          state_d = ST_IDLE;
        end else if (byte_valid) begin
          hi_byte_d = byte_data;
          state_d   = ST_LO;
        end
      end

      ST_LO: begin
        if (load_end) begin
          // Any captured high byte is abandoned.
          state_d = ST_IDLE;
        end else if (byte_valid) begin
          state_d = ST_HI;
          // Address and count stop advancing once the RAM is full, which
          // makes load_count saturate at 0xFFD.
          if (load_addr_q < C_CNT_ADDR) begin
            load_addr_d = load_addr_q + 12'd1;
            load_cnt_d  = load_cnt_q + 12'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // I/O register next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // A processor write to the counter address clears it in place of the
    // increment; the counter wraps naturally at 16 bits.
    if (w_cpu_we && (address == C_CNT_ADDR)) begin
      counter_d = 16'h0000;
    end else begin
      counter_d = counter_q + 16'd1;
    end

    if (w_cpu_we && (address == C_OUT_ADDR)) begin
      out_port_d = data_in;
    end else begin
      out_port_d = out_port_q;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_addr_q <= 12'h000;
      load_cnt_q  <= 12'h000;
      hi_byte_q   <= 8'h00;
      counter_q   <= 16'h0000;
      out_port_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      load_cnt_q  <= load_cnt_d;
      hi_byte_q   <= hi_byte_d;
      counter_q   <= counter_d;
      out_port_q  <= out_port_d;
    end
  end

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      mem_q[w_ram_addr] <= w_ram_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read path: asynchronous, so a read alongside a write sees the old value.
  // --------------------------------------------------------------------------
  always_comb begin
    data_out = 16'h0000;
    if (memory_read) begin
      case (address)
        C_CNT_ADDR: data_out = counter_q;
        C_OUT_ADDR: data_out = out_port_q;
        C_IN_ADDR:  data_out = in_port;
        default:    data_out = mem_q[address];
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_port   = out_port_q;
  assign cpu_hold   = w_loading;
  assign byte_ready = w_loading;
  assign load_count = load_cnt_q;

endmodule
`default_nettype wire

// File: doc/mu0_memory.md
MU0_MEMORY -- requirements
Module: mu0_memory

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- address  input  12  word address from processor
- data_in  input  16  write data from processor
- data_out  output  16  read data to processor
- memory_read  input  1  processor read enable
- memory_write  input  1  processor write enable
- in_port  input  16  external switch inputs
- out_port  output  16  registered output port
- load_start  input  1  begin program load (pulse)
- load_end  input  1  end program load (pulse)
- byte_valid  input  1  loader byte offered
- byte_data  input  8  loader byte
- byte_ready  output  1  loader byte accepted when high with byte_valid
- cpu_hold  output  1  high while loading; drives processor rst externally
- load_count  output  12  words written by the current or last load
REQ-002 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-003 SHALL map the memory as follows:
- RAM at 0x000-0xFFC, 16-bit words
- cycle counter at 0xFFD
- out_port at 0xFFE
- in_port at 0xFFF
REQ-004 SHALL drive data_out combinationally in the same cycle as the read:
- memory_read=1: data_out = the selected RAM word / counter / out_port / in_port
- memory_read=0: data_out = 0x0000
REQ-005 SHALL, on a clk edge with memory_write=1 and cpu_hold=0:
- address in RAM: write data_in to RAM[address]
- 0xFFE: load out_port with data_in
- 0xFFD: clear the counter to 0 (data ignored)
- 0xFFF: ignore the write
REQ-006 SHALL, when memory_read=1 and memory_write=1 together, return the pre-write value on data_out and perform the write at the edge.
REQ-007 SHALL increment the 16-bit cycle counter every cycle, wrapping 0xFFFF->0x0000; a clear via REQ-005 takes priority over the increment.
REQ-008 SHALL implement the loader FSM:
- IDLE -> HI on load_start; load_addr=0, load_count=0
- HI: byte_valid captures byte_data as the high byte -> LO
- LO: byte_valid writes {high,byte_data} to RAM[load_addr]; load_addr+1, load_count+1 -> HI
- load_end in HI or LO -> IDLE
REQ-009 SHALL ignore load_start outside IDLE.
REQ-010 SHALL give load_end priority over a simultaneous byte_valid: the byte is dropped and any partial high byte is discarded.
REQ-011 SHALL hold cpu_hold=1 and byte_ready=1 exactly in HI and LO, and 0 in IDLE.
REQ-012 SHALL ignore processor writes while cpu_hold=1; processor reads keep working.
REQ-013 SHALL discard loader words once load_addr reaches 0xFFD; they are not written and load_count does not advance, so load_count saturates at 0xFFD.
REQ-014 SHALL keep load_count stable in IDLE until the next load_start.

Reset
REQ-015 SHALL, on rst at a clk edge, set:
- loader -> IDLE, with load_addr=0 and load_count=0
- out_port=0 and counter=0
- cpu_hold=0 and byte_ready=0
REQ-016 SHALL leave RAM contents unchanged by rst.
REQ-017 SHALL let rst asserted mid-load abort the load, with no partial word written that cycle.

Verification
REQ-018 SHALL cover these directed scenarios:
- Write 0x1234 to 0x010, then read 0x010 with memory_read=1 -> data_out=0x1234 in the same cycle; with memory_read=0 -> 0x0000.
- Write 0xBEEF to 0xFFE -> out_port=0xBEEF next cycle; set in_port=0x5A5A and read 0xFFF -> 0x5A5A; write to 0xFFF -> no effect.
- Reset, then idle 5 cycles, then read 0xFFD -> 0x0005; write 0xFFD -> next read one cycle later = 0x0001.
- Run load_start, then bytes 0x70,0x05,0x00,0x0A, then load_end -> RAM[0]=0x7005, RAM[1]=0x000A, load_count=2, cpu_hold high only during the load.
- Send a byte with load_end in the same cycle while in LO -> no write; return to IDLE; load_count unchanged.
- Issue a processor write to 0x020 with cpu_hold=1 -> RAM[0x020] unchanged; assert rst in LO -> IDLE, cpu_hold=0.
